// File: rtl/key_sched_pkg.sv
// Shared types and constants for the key event scheduler.
package key_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } sched_state_t;

  localparam int CNT_W = 16;

  function automatic int key_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/key_event_sched_if.sv
// Event handshake bundle between the scheduler (master) and its consumer (slave).
interface key_event_sched_if #(
  parameter int N    = 5,
  parameter int ID_W = 3
) ();
  logic [N-1:0]    key_pulse;
  logic            ev_ready;
  logic            ev_valid;
  logic [ID_W-1:0] ev_id;
  logic [N-1:0]    pending;
  logic            overflow;
  logic            busy;

  modport master (
    input  key_pulse, ev_ready,
    output ev_valid, ev_id, pending, overflow, busy
  );

  modport slave (
    output key_pulse, ev_ready,
    input  ev_valid, ev_id, pending, overflow, busy
  );
endinterface

// File: rtl/key_rr_pick.sv
// Round-robin picker: first set request at or after i_ptr, wrapping past N-1.
module key_rr_pick
  import key_sched_pkg::*;
#(
  parameter int N     = 5,
  parameter int IDX_W = key_clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  int           w_j;
  logic         w_hit;
  logic [N-1:0] w_bit;

  // Scan positions ptr, ptr+1, ... modulo N; the first hit locks the result.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = 0;
    w_hit   = 1'b0;
    w_bit   = '0;
    for (int k = 0; k < N; k++) begin
      w_j     = (int'(i_ptr) + k >= N) ? int'(i_ptr) + k - N : int'(i_ptr) + k;
      w_bit   = ONE << w_j;
      w_hit   = ~o_any & (|(i_req & w_bit));
      o_grant = o_grant | (w_hit ? w_bit : '0);
      o_idx   = w_hit ? w_j[IDX_W-1:0] : o_idx;
      o_any   = o_any | w_hit;
    end
  end

endmodule

// File: rtl/key_event_sched.sv
// Queues per-key press pulses and issues them round-robin as a valid/ready
// event stream with a programmable idle gap after each accepted event.
module key_event_sched
  import key_sched_pkg::*;
#(
  parameter int               N    = 5,
  parameter int               ID_W = 3,
  parameter logic [CNT_W-1:0] GAP  = 16'd255
) (
  input  logic          clk,
  input  logic          rst_n,
  key_event_sched_if.master io
);

  sched_state_t     r_state;
  logic [N-1:0]     r_pending;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_ev_id;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ev_valid;
  logic             r_overflow;
  logic             r_busy;

  logic [N-1:0]     w_grant;
  logic [N-1:0]     w_clr;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;

  key_rr_pick #(.N(N), .IDX_W(ID_W)) u_pick (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // A grant is only taken while idle; it clears the winner's pending bit.
  always_comb begin
    w_clr = '0;
    if (r_state == S_IDLE && w_any) begin
      w_clr = w_grant;
    end else begin
      w_clr = '0;
    end
  end

  // Pending queue, coalesce flag and the issue/gap state machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pending  <= '0;
      r_ptr      <= '0;
      r_ev_id    <= '0;
      r_cnt      <= '0;
      r_ev_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // A new pulse on the bit being granted re-arms it rather than coalescing.
      r_pending  <= (r_pending & ~w_clr) | io.key_pulse;
      r_overflow <= |(io.key_pulse & r_pending & ~w_clr);
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_ev_id    <= w_idx;
            r_ev_valid <= 1'b1;
            r_ptr      <= (w_idx == ID_W'(N - 1)) ? '0 : w_idx + ID_W'(1);
            r_state    <= S_ISSUE;
            r_busy     <= 1'b1;
          end else begin
            r_busy     <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_ev_valid && io.ev_ready) begin
            r_ev_valid <= 1'b0;
            if (GAP == '0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt   <= GAP - 16'd1;
              r_state <= S_GAP;
              r_busy  <= 1'b1;
            end
          end else begin
            r_busy <= 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt - 16'd1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_ev_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign io.ev_valid = r_ev_valid;
  assign io.ev_id    = r_ev_id;
  assign io.pending  = r_pending;
  assign io.overflow = r_overflow;
  assign io.busy     = r_busy;

endmodule

// File: tb/tb_key_event_sched.sv
// Scoreboard bench: one scheduler with GAP=4 and one with GAP=0.
module tb_key_event_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_event_sched_if #(.N(5), .ID_W(3)) ifa ();
  key_event_sched_if #(.N(5), .ID_W(3)) ifb ();

  key_event_sched #(.N(5), .ID_W(3), .GAP(16'd4)) u_dut_gap4 (
    .clk(clk), .rst_n(rst_n), .io(ifa)
  );
  key_event_sched #(.N(5), .ID_W(3), .GAP(16'd0)) u_dut_gap0 (
    .clk(clk), .rst_n(rst_n), .io(ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int qa[$];
  int qb[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n && ifa.ev_valid && ifa.ev_ready) begin
      if (qa.size() == 0) check("gap4 unexpected event id", int'(ifa.ev_id), -1);
      else check("gap4 ev_id", int'(ifa.ev_id), qa.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && ifb.ev_valid && ifb.ev_ready) begin
      if (qb.size() == 0) check("gap0 unexpected event id", int'(ifb.ev_id), -1);
      else check("gap0 ev_id", int'(ifb.ev_id), qb.pop_front());
    end
  end

  int       vcnt;
  int       bcnt;
  int       ocnt;
  int       stable;
  logic [9:0] hist;

  initial begin
    ifa.key_pulse = 5'b0; ifa.ev_ready = 1'b0;
    ifb.key_pulse = 5'b0; ifb.ev_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset ev_valid", int'(ifa.ev_valid), 0);
    check("reset ev_id", int'(ifa.ev_id), 0);
    check("reset pending", int'(ifa.pending), 0);
    check("reset overflow", int'(ifa.overflow), 0);
    check("reset busy", int'(ifa.busy), 0);
    check("reset gap0 busy", int'(ifb.busy), 0);
    tick();
    rst_n = 1'b1;

    // Single press, GAP=4
    ifa.ev_ready  = 1'b1;
    qa.push_back(2);
    ifa.key_pulse = 5'b00100;
    tick();
    ifa.key_pulse = 5'b0;
    @(negedge clk);
    check("single pending after 1 edge", int'(ifa.pending), 4);
    check("single valid not yet", int'(ifa.ev_valid), 0);
    vcnt = 0; bcnt = 0;
    repeat (12) begin
      @(negedge clk);
      vcnt += int'(ifa.ev_valid);
      bcnt += int'(ifa.busy);
    end
    check("single valid cycles", vcnt, 1);
    check("single busy cycles", bcnt, 5);
    check("single pending cleared", int'(ifa.pending), 0);

    // Backpressure on key 3, re-press then coalesced press
    tick();
    ifa.ev_ready  = 1'b0;
    qa.push_back(3);
    ifa.key_pulse = 5'b01000;
    tick();
    ifa.key_pulse = 5'b0;
    tick();
    stable = 1; ocnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!(ifa.ev_valid == 1'b1 && ifa.ev_id == 3'd3)) stable = 0;
      ocnt += int'(ifa.overflow);
      tick();
      ifa.key_pulse = (c == 2 || c == 5) ? 5'b01000 : 5'b0;
      if (c == 2) qa.push_back(3);
    end
    check("backpressure valid/id stable", stable, 1);
    check("coalesce overflow cycles", ocnt, 1);
    check("coalesce pending key3", int'(ifa.pending), 8);
    ifa.ev_ready = 1'b1;
    repeat (20) tick();
    check("gap4 outstanding events", qa.size(), 0);
    check("gap4 idle busy", int'(ifa.busy), 0);
    check("gap4 idle pending", int'(ifa.pending), 0);

    // Async reset in the middle of ISSUE
    ifa.ev_ready  = 1'b0;
    ifa.key_pulse = 5'b00010;
    tick();
    ifa.key_pulse = 5'b10000;
    tick();
    ifa.key_pulse = 5'b0;
    @(negedge clk);
    check("pre-reset valid", int'(ifa.ev_valid), 1);
    check("pre-reset pending", int'(ifa.pending), 16);
    #2 rst_n = 1'b0;
    #1;
    check("async reset valid", int'(ifa.ev_valid), 0);
    check("async reset pending", int'(ifa.pending), 0);
    check("async reset busy", int'(ifa.busy), 0);
    tick();
    rst_n = 1'b1;
    ifa.ev_ready = 1'b1;
    vcnt = 0;
    repeat (15) begin
      @(negedge clk);
      vcnt += int'(ifa.ev_valid);
    end
    check("post-reset spurious valid", vcnt, 0);

    // Simultaneous presses, GAP=0: back-to-back grants two edges apart
    tick();
    ifb.ev_ready = 1'b1;
    qb.push_back(0); qb.push_back(2); qb.push_back(4);
    ifb.key_pulse = 5'b10101;
    tick();
    ifb.key_pulse = 5'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hist[i] = ifb.ev_valid;
    end
    check("gap0 valid pattern", int'(hist), 42);
    check("gap0 simultaneous outstanding", qb.size(), 0);

    // Pointer wrapped to 0: key 0 ahead of key 1
    tick();
    qb.push_back(0); qb.push_back(1);
    ifb.key_pulse = 5'b00011;
    tick();
    ifb.key_pulse = 5'b0;
    repeat (8) tick();
    // ptr now 2; granting key 0 leaves ptr at 1
    qb.push_back(0);
    ifb.key_pulse = 5'b00001;
    tick();
    ifb.key_pulse = 5'b0;
    repeat (8) tick();
    qb.push_back(1); qb.push_back(0);
    ifb.key_pulse = 5'b00011;
    tick();
    ifb.key_pulse = 5'b0;
    repeat (8) tick();
    check("gap0 fairness outstanding", qb.size(), 0);
    check("gap0 final pending", int'(ifb.pending), 0);
    check("gap0 final busy", int'(ifb.busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
